// File: rtl/pif_cmd_regs_pkg.sv
// ---------------------------------------------------------------------------
// pif_cmd_regs_pkg
// Shared definitions for the PIF command decoder / register bank.
//   - command prefix codes carried in rx_data[7:6]
//   - payload width of one command byte
//   - FSM state encodings used by pif_cmd_regs
//   - small integer helper for derived sizes
// ---------------------------------------------------------------------------
package pif_cmd_regs_pkg;

    localparam int I2C_DATA_BITS = 6;

    localparam logic [1:0] A_ADDR = 2'b00;   // set register pointer
    localparam logic [1:0] D_ADDR = 2'b01;   // data byte, commits the register
    localparam logic [1:0] X_ADDR = 2'b10;   // data extension, shifts into staging
    localparam logic [1:0] R_ADDR = 2'b11;   // reserved

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_TXPEND = 2'd2;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/pif_cmd_rdmux.sv
// ---------------------------------------------------------------------------
// pif_cmd_rdmux
// Combinational readback byte selection. Picks status (pointer 0) or the
// addressed register, then the byte selected by byte_idx (LSB byte first,
// upper unused bits zero). An out-of-range pointer returns 8'hFF.
//
// Ports:
//   status    in  REG_WIDTH                 value returned for address 0
//   regs_flat in  (NUM_REGS-1)*REG_WIDTH    registers 1..NUM_REGS-1
//   ptr       in  DATA_BITS                 register pointer
//   byte_idx  in  BI_W                      byte index within the register
//   rd_byte   out 8                         selected read byte
// ---------------------------------------------------------------------------
module pif_cmd_rdmux #(
    parameter int NUM_REGS  = 4,
    parameter int REG_WIDTH = 6,
    parameter int DATA_BITS = 6,
    parameter int NB        = 1,
    parameter int BI_W      = 1
) (
    input  logic [REG_WIDTH-1:0]              status,
    input  logic [(NUM_REGS-1)*REG_WIDTH-1:0] regs_flat,
    input  logic [DATA_BITS-1:0]              ptr,
    input  logic [BI_W-1:0]                   byte_idx,
    output logic [7:0]                        rd_byte
);

    logic [REG_WIDTH-1:0] src;
    logic [NB*8-1:0]      padded;

    always_comb begin
        src = status;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (32'(ptr) == i) src = regs_flat[(i-1)*REG_WIDTH +: REG_WIDTH];
        end
        padded = '0;
        padded[REG_WIDTH-1:0] = src;
        rd_byte = 8'h00;
        for (int b = 0; b < NB; b++) begin
            if (32'(byte_idx) == b) rd_byte = padded[b*8 +: 8];
        end
        if (32'(ptr) >= NUM_REGS) rd_byte = 8'hFF;
    end

endmodule

// File: rtl/pif_cmd_regs.sv
// ---------------------------------------------------------------------------
// pif_cmd_regs
// Command decoder and register bank behind the PIF I2C slave byte interface.
// Command byte = {prefix[1:0], payload[DATA_BITS-1:0]}:
//   A_ADDR sets the pointer, X_ADDR shifts payload into staging,
//   D_ADDR commits {staging, payload} to reg[pointer], R_ADDR is reserved.
// Register 0 is read-only and reads back the status input.
//
// Optional build macro: PIF_CMDREG_AUTOINC_EN
//   defined   - pointer increments after each successful commit and after the
//               last byte of each register read (wraps mod 2**DATA_BITS)
//   undefined - pointer changes only on A_ADDR
//
// Ports:
//   CLK        in   1                    system clock
//   GSRn       in   1                    async active-low reset
//   bus_start  in   1                    START / repeated START pulse
//   bus_stop   in   1                    STOP pulse
//   rx_valid   in   1                    rx_data holds a received byte
//   rx_data    in   8                    command byte
//   tx_req     in   1                    next read byte requested
//   tx_valid   out  1                    tx_data valid strobe
//   tx_data    out  8                    read byte
//   status     in   REG_WIDTH            readback for address 0
//   reg_q      out  NUM_REGS*REG_WIDTH   flattened registers, slice 0 = 0
//   reg_wr     out  NUM_REGS             per-register commit pulse
//   err        out  1                    sticky error, cleared by GSRn only
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no transaction; rx ignored, tx_req answered with 8'hFF + err
// S_ACTIVE | addressed; rx decoded, tx_req served next cycle
// S_TXPEND | tx_req collided with rx; read byte is served this cycle
// ---------------------------------------------------------------------------
module pif_cmd_regs
    import pif_cmd_regs_pkg::*;
#(
    parameter int                   NUM_REGS  = 4,
    parameter int                   REG_WIDTH = 6,
    parameter int                   DATA_BITS = I2C_DATA_BITS,
    parameter logic [REG_WIDTH-1:0] RST_VAL   = '0
) (
    input  logic                          CLK,
    input  logic                          GSRn,
    input  logic                          bus_start,
    input  logic                          bus_stop,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          tx_req,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    input  logic [REG_WIDTH-1:0]          status,
    output logic [NUM_REGS*REG_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]           reg_wr,
    output logic                          err
);

    localparam int NX    = ceil_div(REG_WIDTH, DATA_BITS) - 1;
    localparam int NB    = ceil_div(REG_WIDTH, 8);
    // With no extension bytes the staging register is a single bit held at 0.
    localparam int STG_W = (NX > 0) ? NX * DATA_BITS : 1;
    localparam int BI_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int CAT_W = STG_W + DATA_BITS;

    logic [1:0]                    state, state_n;
    logic [DATA_BITS-1:0]          ptr, ptr_n;
    logic [STG_W-1:0]              stg, stg_n;
    logic [BI_W-1:0]               bidx, bidx_n;
    logic                          err_n;
    logic                          tx_valid_n;
    logic [7:0]                    tx_data_n;
    logic [NUM_REGS-1:0]           reg_wr_n;
    logic [NUM_REGS*REG_WIDTH-1:0] q_r;
    logic                          wr_en;

    logic [1:0]           prefix;
    logic [DATA_BITS-1:0] payload;
    logic [CAT_W-1:0]     cat;
    logic [REG_WIDTH-1:0] value;
    logic                 unused_cat;
    logic                 ptr_zero;
    logic                 ptr_oob;
    logic                 serve;
    logic [7:0]           rd_byte;

    assign prefix     = rx_data[7:6];
    assign payload    = rx_data[DATA_BITS-1:0];
    assign cat        = {stg, payload};
    assign value      = cat[REG_WIDTH-1:0];
    assign unused_cat = ^cat;
    assign ptr_zero   = (ptr == '0);
    assign ptr_oob    = (32'(ptr) >= NUM_REGS);
    assign reg_q      = q_r;

    pif_cmd_rdmux #(
        .NUM_REGS  (NUM_REGS),
        .REG_WIDTH (REG_WIDTH),
        .DATA_BITS (DATA_BITS),
        .NB        (NB),
        .BI_W      (BI_W)
    ) u_rdmux (
        .status    (status),
        .regs_flat (q_r[NUM_REGS*REG_WIDTH-1:REG_WIDTH]),
        .ptr       (ptr),
        .byte_idx  (bidx),
        .rd_byte   (rd_byte)
    );

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        stg_n      = stg;
        bidx_n     = bidx;
        err_n      = err;
        tx_valid_n = 1'b0;
        tx_data_n  = tx_data;
        wr_en      = 1'b0;
        serve      = 1'b0;

        if (bus_stop) begin
            state_n = S_IDLE;
            stg_n   = '0;
            bidx_n  = '0;
        end else if (bus_start) begin
            state_n = S_ACTIVE;
            stg_n   = '0;
            bidx_n  = '0;
        end else begin
            if (rx_valid && (state != S_IDLE)) begin
                case (prefix)
                    A_ADDR: begin
                        ptr_n  = payload;
                        stg_n  = '0;
                        bidx_n = '0;
                    end
                    X_ADDR: begin
                        if (NX > 0) stg_n = cat[STG_W-1:0];
                        else        err_n = 1'b1;
                    end
                    D_ADDR: begin
                        stg_n = '0;
                        if (ptr_zero || ptr_oob) begin
                            err_n = 1'b1;
                        end else begin
                            wr_en = 1'b1;
`ifdef PIF_CMDREG_AUTOINC_EN
                            ptr_n = ptr + 1'b1;
`endif
                        end
                    end
                    R_ADDR:  err_n = 1'b1;
                    default: err_n = 1'b1;
                endcase
            end

            // A read colliding with a received byte is deferred one cycle so
            // it observes the result of that byte.
            if (state == S_TXPEND) begin
                serve   = 1'b1;
                state_n = S_ACTIVE;
            end else if ((state == S_ACTIVE) && tx_req) begin
                if (rx_valid) state_n = S_TXPEND;
                else          serve   = 1'b1;
            end else if ((state == S_IDLE) && tx_req) begin
                tx_valid_n = 1'b1;
                tx_data_n  = 8'hFF;
                err_n      = 1'b1;
            end

            if (serve) begin
                tx_valid_n = 1'b1;
                tx_data_n  = rd_byte;
                if (ptr_oob) err_n = 1'b1;
                if (bidx == BI_W'(NB - 1)) begin
                    bidx_n = '0;
`ifdef PIF_CMDREG_AUTOINC_EN
                    ptr_n  = ptr + 1'b1;
`endif
                end else begin
                    bidx_n = bidx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        reg_wr_n = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en && (32'(ptr) == i)) reg_wr_n[i] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge GSRn) begin
        if (!GSRn) begin
            state    <= S_IDLE;
            ptr      <= '0;
            stg      <= '0;
            bidx     <= '0;
            err      <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            reg_wr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                q_r[i*REG_WIDTH +: REG_WIDTH] <= (i == 0) ? '0 : RST_VAL;
            end
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            stg      <= stg_n;
            bidx     <= bidx_n;
            err      <= err_n;
            tx_valid <= tx_valid_n;
            tx_data  <= tx_data_n;
            reg_wr   <= reg_wr_n;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (reg_wr_n[i]) q_r[i*REG_WIDTH +: REG_WIDTH] <= value;
            end
        end
    end

endmodule
